// File: rtl/lcd_pkg.sv
// Shared types and default timing for the character-LCD write engine.
// Holds the FSM state encoding and the 4-bit power-on init tables.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_TX,
    INIT_GAP,
    IDLE,
    TX_HI,
    GAP_HI,
    TX_LO,
    GAP_CMD
  } lcd_state_t;

  // Defaults are 50 MHz cycle counts.
  localparam int unsigned DEF_CNT_W     = 20;
  localparam int unsigned DEF_T_POWERON = 750000;
  localparam int unsigned DEF_T_INIT1   = 205000;
  localparam int unsigned DEF_T_INIT2   = 5000;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_EPULSE  = 12;
  localparam int unsigned DEF_T_HOLD    = 1;
  localparam int unsigned DEF_T_NIBBLE  = 50;
  localparam int unsigned DEF_T_CMD     = 2000;

  localparam logic [3:0] INIT_NIBBLES [4] = '{4'h3, 4'h3, 4'h3, 4'h2};

  // Gap after each init nibble; the timings are module parameters, so this is a lookup.
  function automatic int unsigned init_gap(input logic [1:0]  idx,
                                           input int unsigned t_init1,
                                           input int unsigned t_init2,
                                           input int unsigned t_cmd);
    case (idx)
      2'd0:    return t_init1;
      2'd1:    return t_init2;
      default: return t_cmd;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_engine_nibble_tx.sv
// Single-nibble LCD strobe: setup, enable pulse, hold; owns the LCD data/RS/E pins.
// done_c is high on the last hold cycle so the sequencer can leave its state on that edge.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned T_SETUP  = DEF_T_SETUP,
  parameter int unsigned T_EPULSE = DEF_T_EPULSE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       done_c,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       lcd_rs
);

  localparam int unsigned T_TOTAL = T_SETUP + T_EPULSE + T_HOLD;
  localparam int unsigned E_ON    = T_SETUP;
  localparam int unsigned E_OFF   = T_SETUP + T_EPULSE;

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);
  assign done_c  = busy && (cnt == CNT_W'(T_TOTAL - 1));

  // Data and RS are captured on start and left in place after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      sf_d   <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      sf_d   <= nibble;
      lcd_rs <= rs;
      lcd_e  <= (E_ON == 0);
    end else if (busy) begin
      if (done_c) begin
        busy  <= 1'b0;
        cnt   <= '0;
        lcd_e <= 1'b0;
      end else begin
        cnt   <= cnt_inc;
        lcd_e <= (cnt_inc >= CNT_W'(E_ON)) && (cnt_inc < CNT_W'(E_OFF));
      end
    end
  end

endmodule

// File: rtl/lcd_write_engine.sv
// Character-LCD write engine: 4-bit power-on init, then byte writes over valid/ready
// as two timed nibble strobes on SF_D[11:8]/LCD_E/LCD_RS.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned T_POWERON = DEF_T_POWERON,
  parameter int unsigned T_INIT1   = DEF_T_INIT1,
  parameter int unsigned T_INIT2   = DEF_T_INIT2,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_EPULSE  = DEF_T_EPULSE,
  parameter int unsigned T_HOLD    = DEF_T_HOLD,
  parameter int unsigned T_NIBBLE  = DEF_T_NIBBLE,
  parameter int unsigned T_CMD     = DEF_T_CMD
) (
  input  logic       CLK_50MHZ,
  input  logic       BTN_NORTH,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  // The first IDLE cycle completes a final T_CMD gap, so a held request repeats
  // exactly once per byte period.
  localparam int unsigned LAST_GAP_END = (T_CMD > 1) ? T_CMD - 2 : 0;

  lcd_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic [3:0]       lo_q;
  logic             rs_q;

  logic             tx_start_c;
  logic [3:0]       tx_nibble_c;
  logic             tx_rs_c;
  logic             tx_done_c;
  logic             accept_c;
  logic [CNT_W-1:0] gap_end_c;

  assign LCD_RW = 1'b0;

  lcd_nibble_tx #(
    .CNT_W   (CNT_W),
    .T_SETUP (T_SETUP),
    .T_EPULSE(T_EPULSE),
    .T_HOLD  (T_HOLD)
  ) u_tx (
    .clk   (CLK_50MHZ),
    .rst_n (BTN_NORTH),
    .start (tx_start_c),
    .nibble(tx_nibble_c),
    .rs    (tx_rs_c),
    .done_c(tx_done_c),
    .sf_d  (SF_D),
    .lcd_e (LCD_E),
    .lcd_rs(LCD_RS)
  );

  always_ff @(posedge CLK_50MHZ or negedge BTN_NORTH) begin
    if (!BTN_NORTH) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      lo_q      <= '0;
      rs_q      <= 1'b0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      cmd_ready <= (state_n == IDLE);
      init_done <= init_done | (state_n == IDLE);
      if (accept_c) begin
        lo_q <= cmd_data[3:0];
        rs_q <= cmd_rs;
      end
    end
  end

  // Next-state logic; a nibble strobe starts on the edge that enters a TX state.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    idx_n       = idx;
    tx_start_c  = 1'b0;
    tx_nibble_c = '0;
    tx_rs_c     = 1'b0;
    accept_c    = 1'b0;
    gap_end_c   = '0;

    unique case (state)
      PWR_WAIT: begin
        if (cnt == CNT_W'(T_POWERON - 1)) begin
          state_n     = INIT_TX;
          idx_n       = '0;
          tx_start_c  = 1'b1;
          tx_nibble_c = INIT_NIBBLES[0];
        end
      end
      INIT_TX: begin
        if (tx_done_c) state_n = INIT_GAP;
      end
      INIT_GAP: begin
        gap_end_c = (idx == 2'd3) ? CNT_W'(LAST_GAP_END)
                                  : CNT_W'(init_gap(idx, T_INIT1, T_INIT2, T_CMD) - 1);
        if (cnt == gap_end_c) begin
          if (idx == 2'd3) begin
            state_n = IDLE;
          end else begin
            idx_n       = idx + 2'd1;
            state_n     = INIT_TX;
            tx_start_c  = 1'b1;
            tx_nibble_c = INIT_NIBBLES[idx_n];
          end
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          accept_c    = 1'b1;
          state_n     = TX_HI;
          tx_start_c  = 1'b1;
          tx_nibble_c = cmd_data[7:4];
          tx_rs_c     = cmd_rs;
        end
      end
      TX_HI: begin
        if (tx_done_c) state_n = GAP_HI;
      end
      GAP_HI: begin
        if (cnt == CNT_W'(T_NIBBLE - 1)) begin
          state_n     = TX_LO;
          tx_start_c  = 1'b1;
          tx_nibble_c = lo_q;
          tx_rs_c     = rs_q;
        end
      end
      TX_LO: begin
        if (tx_done_c) state_n = GAP_CMD;
      end
      GAP_CMD: begin
        if (cnt == CNT_W'(LAST_GAP_END)) state_n = IDLE;
      end
    endcase

    if (state_n != state) cnt_n = '0;
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine with shortened timing; expected strobe
// timelines come from the documented cycle arithmetic, not from DUT internals.
module tb_lcd_write_engine;

  localparam int unsigned T_POWERON = 10;
  localparam int unsigned T_INIT1   = 8;
  localparam int unsigned T_INIT2   = 4;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_EPULSE  = 3;
  localparam int unsigned T_HOLD    = 1;
  localparam int unsigned T_NIBBLE  = 3;
  localparam int unsigned T_CMD     = 6;
  localparam int unsigned T_NIB     = T_SETUP + T_EPULSE + T_HOLD;
  localparam int unsigned T_BYTE    = 2 * T_NIB + T_NIBBLE + T_CMD;
  localparam int unsigned T_INITDONE = T_POWERON + 4 * T_NIB + T_INIT1 + T_INIT2 + 2 * T_CMD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, LCD_E, LCD_RS, LCD_RW;
  logic [3:0] SF_D;

  lcd_write_engine #(
    .CNT_W(20), .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_SETUP(T_SETUP), .T_EPULSE(T_EPULSE), .T_HOLD(T_HOLD),
    .T_NIBBLE(T_NIBBLE), .T_CMD(T_CMD)
  ) dut (
    .CLK_50MHZ(clk), .BTN_NORTH(rst_n), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .init_done(init_done),
    .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned rise;
    int unsigned width;
    logic [3:0]  nib;
    logic        rs;
    logic        stable;
  } pulse_t;

  pulse_t      obs_q[$];
  pulse_t      exp_q[$];
  pulse_t      cur;
  logic        e_prev = 1'b0;
  logic [3:0]  prev_sfd = 4'h0;
  logic        prev_rs = 1'b0;
  int unsigned rw_bad = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  // Records every enable pulse: rise cycle, width, and data/RS seen at the rise.
  always @(negedge clk) begin
    if (LCD_RW !== 1'b0) rw_bad <= rw_bad + 1;
    if (LCD_E === 1'b1 && !e_prev) begin
      cur.rise   <= cyc;
      cur.width  <= 1;
      cur.nib    <= SF_D;
      cur.rs     <= LCD_RS;
      cur.stable <= (prev_sfd === SF_D) && (prev_rs === LCD_RS);
    end else if (LCD_E === 1'b1) begin
      cur.width <= cur.width + 1;
      if (SF_D !== cur.nib || LCD_RS !== cur.rs) cur.stable <= 1'b0;
    end else if (e_prev) begin
      obs_q.push_back(cur);
    end
    e_prev   <= (LCD_E === 1'b1);
    prev_sfd <= SF_D;
    prev_rs  <= LCD_RS;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, output int unsigned at);
    int unsigned n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(cmd_ready), 32'd1);
    at = cyc;
  endtask

  function automatic void push_exp(input int unsigned rise, input logic [3:0] nib, input logic rs);
    pulse_t p;
    p.rise = rise; p.width = T_EPULSE; p.nib = nib; p.rs = rs; p.stable = 1'b1;
    exp_q.push_back(p);
  endfunction

  // Accept seen in cycle a: high nibble strobe starts there, low one after TX + gap.
  function automatic void exp_byte(input int unsigned a, input logic [7:0] d, input logic rs);
    logic [7:0] v;
    v = d;
    push_exp(a + T_SETUP, v[7:4], rs);
    push_exp(a + T_NIB + T_NIBBLE + T_SETUP, v[3:0], rs);
  endfunction

  function automatic void exp_init(input int unsigned rel);
    int unsigned s;
    int unsigned gaps[4];
    logic [3:0]  nibs[4];
    gaps = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    s = rel + T_POWERON;
    for (int i = 0; i < 4; i++) begin
      push_exp(s + T_SETUP, nibs[i], 1'b0);
      s = s + T_NIB + gaps[i];
    end
  endfunction

  task automatic compare_pulses(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_nib%0d", tag, i), 32'(obs_q[i].nib), 32'(exp_q[i].nib));
      check($sformatf("%s_rs%0d", tag, i), 32'(obs_q[i].rs), 32'(exp_q[i].rs));
      check($sformatf("%s_width%0d", tag, i), obs_q[i].width, exp_q[i].width);
      check($sformatf("%s_rise%0d", tag, i), obs_q[i].rise, exp_q[i].rise);
      check($sformatf("%s_stable%0d", tag, i), 32'(obs_q[i].stable), 32'(exp_q[i].stable));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rs, output int unsigned a);
    int unsigned r;
    wait_ready("send_ready", r);
    cmd_valid = 1'b1; cmd_data = d; cmd_rs = rs;
    a = cyc + 1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int unsigned rel, at, a1, a2, n;
    logic [7:0]  d;
    logic        rs;
    logic        glitch;

    // Reset values
    repeat (3) tick();
    check("rst_sfd", 32'(SF_D), 32'd0);
    check("rst_e", 32'(LCD_E), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Power-on init with no requests
    rst_n = 1'b1;
    rel = cyc;
    wait_ready("init_ready", at);
    check("init_ready_cycle", at, rel + T_INITDONE - 1);
    check("init_done_with_ready", 32'(init_done), 32'd1);
    exp_init(rel);
    compare_pulses("init");

    // Single data byte 0x41
    send_byte(8'h41, 1'b1, a1);
    exp_byte(a1, 8'h41, 1'b1);
    check("b41_ready_drop", 32'(cmd_ready), 32'd0);
    wait_ready("b41_ready", at);
    check("b41_ready_cycle", at, a1 + T_BYTE - 1);
    compare_pulses("b41");

    // Held valid: 0x28 then 0x0C back to back
    cmd_valid = 1'b1; cmd_data = 8'h28; cmd_rs = 1'b0;
    a1 = cyc + 1;
    tick();
    cmd_data = 8'h0C;
    a2 = a1 + T_BYTE;
    exp_byte(a1, 8'h28, 1'b0);
    exp_byte(a2, 8'h0C, 1'b0);
    while (cyc < a2 - 2) tick();
    check("held_not_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("held_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("held_accept2", 32'(cmd_ready), 32'd0);
    wait_ready("held_ready_end", at);
    check("held_ready_cycle", at, a2 + T_BYTE - 1);
    compare_pulses("held");

    // Random bytes, some with a stray valid pulse mid-transfer
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      glitch = (k % 2) == 1;
      repeat ($urandom_range(0, 3)) tick();
      send_byte(d, rs, a1);
      exp_byte(a1, d, rs);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
        if (glitch && cyc == a1 + 5) begin
          cmd_valid = 1'b1; cmd_data = ~d;
        end else begin
          cmd_valid = 1'b0;
        end
        tick();
        n++;
      end
      cmd_valid = 1'b0;
      check($sformatf("rnd%0d_ready", k), 32'(cmd_ready), 32'd1);
      check($sformatf("rnd%0d_ready_cycle", k), cyc, a1 + T_BYTE - 1);
      compare_pulses($sformatf("rnd%0d", k));
    end

    // Reset during an enable pulse, with a request held through the re-init
    send_byte(8'hA5, 1'b1, a1);
    n = 0;
    while (LCD_E !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("mid_e_high", 32'(LCD_E), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_e", 32'(LCD_E), 32'd0);
    check("mid_rst_sfd", 32'(SF_D), 32'd0);
    check("mid_rst_rs", 32'(LCD_RS), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_rs = 1'b1;
    repeat (2) tick();
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    rel = cyc;
    exp_init(rel);
    wait_ready("reinit_ready", at);
    check("reinit_ready_cycle", at, rel + T_INITDONE - 1);
    check("reinit_init_done", 32'(init_done), 32'd1);
    a1 = at + 1;
    exp_byte(a1, 8'h5A, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("reinit_accept", 32'(cmd_ready), 32'd0);
    wait_ready("reinit_byte_ready", at);
    check("reinit_byte_ready_cycle", at, a1 + T_BYTE - 1);
    compare_pulses("reinit");

    check("rw_low", rw_bad, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Character-LCD write engine that sits directly downstream of the CPU/display logic and directly drives the board LCD pins (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).
- After reset it runs the 4-bit power-on initialisation sequence, then accepts byte-wide command/data requests over a valid/ready handshake.
- Each accepted byte is sent as two timed nibble strobes.
- All timing is counted in CLK_50MHZ cycles and parameterised so simulation can shorten the waits.

Parameters:
- CNT_W, 20, width of the shared delay counter; must hold the largest timing parameter.
- T_POWERON, 750000, power-on wait before the first init nibble (15 ms).
- T_INIT1, 205000, gap after init nibble 1 (4.1 ms).
- T_INIT2, 5000, gap after init nibble 2 (100 us).
- T_SETUP, 2, cycles SF_D/LCD_RS are stable before LCD_E rises.
- T_EPULSE, 12, cycles LCD_E is held high.
- T_HOLD, 1, cycles SF_D/LCD_RS are held after LCD_E falls.
- T_NIBBLE, 50, gap between the high and low nibble of one byte (1 us).
- T_CMD, 2000, gap after a complete byte and after init nibbles 3 and 4 (40 us).

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz.
- BTN_NORTH  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  request present.
- cmd_rs  in  1  0 = instruction, 1 = data; sampled on accept.
- cmd_data  in  8  byte to write; sampled on accept.
- cmd_ready  out  1  engine idle and initialised.
- init_done  out  1  power-on sequence complete; sticky until reset.
- SF_D  out  4  LCD data nibble, driven as [11:8].
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/write; tied to 0 (write only).

Behaviour:
- Reset (BTN_NORTH = 0, asynchronous):
  - SF_D = 0, LCD_E = 0, LCD_RS = 0, LCD_RW = 0, cmd_ready = 0, init_done = 0.
  - FSM goes to PWR_WAIT and the counter clears.
  - Reset mid-transfer drops LCD_E immediately and restarts the full init sequence; no partial byte is resumed.
- States: PWR_WAIT, INIT_TX, INIT_GAP, IDLE, TX_HI, GAP_HI, TX_LO, GAP_CMD.
- PWR_WAIT:
  - Counts T_POWERON cycles, then moves to INIT_TX with init index 0.
- INIT_TX / INIT_GAP:
  - The init nibble sequence is 0x3, 0x3, 0x3, 0x2, all with LCD_RS = 0.
  - The gaps after them are T_INIT1, T_INIT2, T_CMD, T_CMD.
  - After the 4th gap: init_done = 1, move to IDLE.
- Nibble transfer (INIT_TX, TX_HI, TX_LO), T_SETUP + T_EPULSE + T_HOLD cycles:
  - T_SETUP cycles: SF_D/LCD_RS valid, LCD_E = 0.
  - T_EPULSE cycles: LCD_E = 1.
  - T_HOLD cycles: LCD_E = 0, data still held.
  - SF_D and LCD_RS keep their last value afterwards until the next nibble.
- IDLE and handshake:
  - cmd_ready = 1 only in IDLE.
  - Accept occurs on the rising edge where cmd_valid && cmd_ready; cmd_rs and cmd_data are latched.
  - cmd_ready is 0 from the next cycle.
  - cmd_valid is ignored while cmd_ready = 0; there is no queuing.
- Byte sequence after accept:
  - TX_HI sends cmd_data[7:4], then GAP_HI waits T_NIBBLE.
  - TX_LO sends cmd_data[3:0], then GAP_CMD waits T_CMD, then IDLE.
  - The first setup cycle of TX_HI is the cycle right after the accept edge.
- Latency:
  - cmd_ready returns exactly 2*(T_SETUP+T_EPULSE+T_HOLD) + T_NIBBLE + T_CMD cycles after the accept edge (2080 with defaults).
  - A source holding cmd_valid high gets back-to-back accepts at that period.
- init_done latency from reset release: T_POWERON + 4*(T_SETUP+T_EPULSE+T_HOLD) + T_INIT1 + T_INIT2 + 2*T_CMD cycles.
- Counter: a single down/up counter of CNT_W bits, reloaded on every state entry; no wrap-around is possible because every parameter < 2^CNT_W.

Decomposition:
- Package lcd_pkg:
  - FSM state enum.
  - Default timing constants.
  - 4-entry init nibble table and init gap table.
- Sub-module lcd_nibble_tx:
  - Inputs: start, nibble, rs.
  - Generates the setup/E/hold timing and pulses done on its final cycle.
  - Owns SF_D, LCD_RS, LCD_E.
- The top FSM sequences the init, handshake and gaps.

Test Plan (sim params: T_POWERON=10, T_INIT1=8, T_INIT2=4, T_SETUP=2, T_EPULSE=3, T_HOLD=1, T_NIBBLE=3, T_CMD=6):
- Reset release, no requests -> four LCD_E pulses of 3 cycles with SF_D = 3,3,3,2, RS = 0; init_done and cmd_ready rise 58 cycles after release; LCD_RW = 0 throughout.
- After init, cmd_rs=1, cmd_data=0x41 for one cycle -> SF_D=0x4 then 0x1, RS=1, two 3-cycle E pulses 3 gap cycles apart; cmd_ready returns 21 cycles after accept.
- cmd_valid held high with 0x28 then 0x0C, RS=0 -> accepts exactly 21 cycles apart; nibbles 2,8,0,C in order.
- cmd_valid pulsed while cmd_ready=0 (mid-byte) -> ignored; no extra E pulse; cmd_ready timing unchanged.
- BTN_NORTH low while LCD_E=1 -> LCD_E=0 asynchronously, all outputs reset; after release the full 58-cycle init reruns before cmd_ready=1.
- cmd_valid high during init -> no accept until init_done=1, then accepted on the first cmd_ready cycle.
